path_walker: RTL

PATH_WALKER -- requirements
Module: path_walker

---
 rtl/path_walker.sv | 126 ++++++++++++
 1 files changed

// File: rtl/path_walker.sv
// Maze path walker: applies a stream of 2-bit moves to a coordinate on a
// square grid, flagging out-of-bounds moves and step-counter overflow.
module path_walker #(
  parameter int COORD_BITS = 4,
  parameter int CNT_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [COORD_BITS-1:0] start_x,
  input  logic [COORD_BITS-1:0] start_y,
  input  logic                  in_valid,
  input  logic [1:0]            in_dir,
  input  logic                  in_done,
  output logic                  out_valid,
  output logic [COORD_BITS-1:0] out_x,
  output logic [COORD_BITS-1:0] out_y,
  output logic [CNT_BITS-1:0]   step_count,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [COORD_BITS-1:0] COORD_MAX = '1;
  localparam logic [CNT_BITS-1:0]   CNT_MAX   = '1;

  state_t                state_q, state_d;
  logic [COORD_BITS-1:0] x_q, x_d;
  logic [COORD_BITS-1:0] y_q, y_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic [COORD_BITS-1:0] nx, ny;
  logic                  oob;

  // Candidate cell and its bounds check, evaluated before any arithmetic
  // result is committed so a wrapped coordinate never reaches the outputs.
  always_comb begin
    nx  = x_q;
    ny  = y_q;
    oob = 1'b0;
    case (in_dir)
      2'b00: begin oob = (y_q == '0);        ny = y_q - 1'b1; end
      2'b01: begin oob = (x_q == COORD_MAX); nx = x_q + 1'b1; end
      2'b10: begin oob = (x_q == '0);        nx = x_q - 1'b1; end
      default: begin oob = (y_q == COORD_MAX); ny = y_q + 1'b1; end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    case (state_q)
      WALK: begin
        if (in_valid) begin
          if (oob || (cnt_q == CNT_MAX)) begin
            state_d = ERR;
          end else begin
            x_d         = nx;
            y_d         = ny;
            cnt_d       = cnt_q + 1'b1;
            out_valid_d = 1'b1;
            state_d     = in_done ? DONE : WALK;
          end
        end else if (in_done) begin
          state_d = DONE;
        end
      end
      default: begin
        if (start) begin
          x_d     = start_x;
          y_d     = start_y;
          cnt_d   = '0;
          state_d = WALK;
        end
      end
    endcase
    busy_d  = (state_d == WALK);
    done_d  = (state_d == DONE);
    error_d = (state_d == ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_x      = x_q;
  assign out_y      = y_q;
  assign step_count = cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
